// File: rtl/blake2_pkg.sv
// Shared BLAKE2 constants: IVs, message schedule, per-width round/rotation
// parameters and the compression FSM state encoding.
package blake2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int NR_B = 12;
  localparam int NR_S = 10;

  localparam int R1_B = 32;
  localparam int R2_B = 24;
  localparam int R3_B = 16;
  localparam int R4_B = 63;

  localparam int R1_S = 16;
  localparam int R2_S = 12;
  localparam int R3_S = 8;
  localparam int R4_S = 7;

  localparam logic [63:0] IV64 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [31:0] IV32 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [3:0] SIGMA [10][16] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
      4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,
      4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3},
    '{4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13,
      4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4},
    '{4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14,
      4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8},
    '{4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15,
      4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13},
    '{4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,
      4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9},
    '{4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10,
      4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11},
    '{4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,
      4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10},
    '{4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,
      4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5},
    '{4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,
      4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0}
  };

endpackage

// File: rtl/blake2_g.sv
// BLAKE2 G mixing function: one column or diagonal quarter-round, purely
// combinational.
module blake2_g #(
  parameter int W  = 64,
  parameter int R1 = 32,
  parameter int R2 = 24,
  parameter int R3 = 16,
  parameter int R4 = 63
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] c_o,
  output logic [W-1:0] d_o
);

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  logic [W-1:0] a1, b1, c1, d1;

  // Additions wrap at W bits by construction of the operand widths.
  assign a1  = a_i + b_i + x_i;
  assign d1  = rotr(d_i ^ a1, R1);
  assign c1  = c_i + d1;
  assign b1  = rotr(b_i ^ c1, R2);
  assign a_o = a1 + b1 + y_i;
  assign d_o = rotr(d1 ^ a_o, R3);
  assign c_o = c1 + d_o;
  assign b_o = rotr(b1 ^ c_o, R4);

endmodule

// File: rtl/blake2_compress.sv
// BLAKE2b/BLAKE2s compression function: one full round (8 G functions) per
// clock, valid/ready handshake on both sides.
module blake2_compress
  import blake2_pkg::*;
#(
  parameter int W = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [8*W-1:0]  h_i,
  input  logic [16*W-1:0] m_i,
  input  logic [2*W-1:0]  t_i,
  input  logic            f_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [8*W-1:0]  h_o
);

  localparam int NR = (W == 64) ? NR_B : NR_S;
  localparam int R1 = (W == 64) ? R1_B : R1_S;
  localparam int R2 = (W == 64) ? R2_B : R2_S;
  localparam int R3 = (W == 64) ? R3_B : R3_S;
  localparam int R4 = (W == 64) ? R4_B : R4_S;

  logic [W-1:0] iv [8];

  if (W == 64) begin : g_iv64
    for (genvar k = 0; k < 8; k++) begin : g_k
      assign iv[k] = IV64[k];
    end
  end else if (W == 32) begin : g_iv32
    for (genvar k = 0; k < 8; k++) begin : g_k
      assign iv[k] = IV32[k];
    end
  end else begin : g_bad_w
    $error("blake2_compress: W must be 64 or 32");
  end

  state_e       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic [W-1:0] v_q [16];
  logic [W-1:0] v_d [16];
  logic [W-1:0] h_q [8];
  logic [W-1:0] h_d [8];
  logic [W-1:0] m_q [16];
  logic [W-1:0] m_d [16];

  logic [3:0]   row;
  logic [W-1:0] msg   [16];
  logic [W-1:0] col_v [16];
  logic [W-1:0] rnd_v [16];

  // Round 10 and 11 reuse schedule rows 0 and 1.
  always_comb begin
    row = (rc_q >= 4'd10) ? rc_q - 4'd10 : rc_q;
    for (int j = 0; j < 16; j++) msg[j] = m_q[SIGMA[row][j]];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    blake2_g #(.W(W), .R1(R1), .R2(R2), .R3(R3), .R4(R4)) u_g (
      .a_i(v_q[gi]),      .b_i(v_q[gi+4]),
      .c_i(v_q[gi+8]),    .d_i(v_q[gi+12]),
      .x_i(msg[2*gi]),    .y_i(msg[2*gi+1]),
      .a_o(col_v[gi]),    .b_o(col_v[gi+4]),
      .c_o(col_v[gi+8]),  .d_o(col_v[gi+12])
    );
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_diag
    localparam int IB = 4 + ((gi + 1) % 4);
    localparam int IC = 8 + ((gi + 2) % 4);
    localparam int ID = 12 + ((gi + 3) % 4);
    blake2_g #(.W(W), .R1(R1), .R2(R2), .R3(R3), .R4(R4)) u_g (
      .a_i(col_v[gi]),    .b_i(col_v[IB]),
      .c_i(col_v[IC]),    .d_i(col_v[ID]),
      .x_i(msg[8+2*gi]),  .y_i(msg[9+2*gi]),
      .a_o(rnd_v[gi]),    .b_o(rnd_v[IB]),
      .c_o(rnd_v[IC]),    .d_o(rnd_v[ID])
    );
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    v_d     = v_q;
    h_d     = h_q;
    m_d     = m_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    h_o     = '0;
    unique case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          for (int k = 0; k < 8; k++) begin
            h_d[k]   = h_i[k*W +: W];
            v_d[k]   = h_i[k*W +: W];
            v_d[k+8] = iv[k];
          end
          for (int k = 0; k < 16; k++) m_d[k] = m_i[k*W +: W];
          v_d[12] = iv[4] ^ t_i[W-1:0];
          v_d[13] = iv[5] ^ t_i[2*W-1:W];
          if (f_i) v_d[14] = ~iv[6];
          rc_d    = '0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        v_d = rnd_v;
        if (rc_q == 4'(NR - 1)) begin
          rc_d    = '0;
          state_d = ST_DONE;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        for (int k = 0; k < 8; k++) h_o[k*W +: W] = h_q[k] ^ v_q[k] ^ v_q[k+8];
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  // Datapath state is only meaningful once loaded by a transfer.
  always_ff @(posedge clk) begin
    v_q <= v_d;
    h_q <= h_d;
    m_q <= m_d;
  end

endmodule

// File: doc/blake2_compress.md
BLAKE2_COMPRESS -- requirements
Module: blake2_compress

Interface
REQ-001 SHALL have parameter W, default 64, meaning word width: 64 selects BLAKE2b, 32 selects BLAKE2s, any other value is an elaboration error.
REQ-002 SHALL derive localparam NR, the round count: 12 when W=64, 10 when W=32.
REQ-003 SHALL derive the rotation constants (R1,R2,R3,R4): (32,24,16,63) when W=64, (16,12,8,7) when W=32.
REQ-004 SHALL have port clk  in  1  clock, with all state on the rising edge.
REQ-005 SHALL have port nreset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port valid_i  in  1  input block valid.
REQ-007 SHALL have port ready_o  out  1  block can accept a new input.
REQ-008 SHALL have port h_i  in  8*W  chaining state, word k at bits [kW+W-1:kW].
REQ-009 SHALL have port m_i  in  16*W  message block, word k at bits [kW+W-1:kW].
REQ-010 SHALL have port t_i  in  2*W  byte offset counter; low word is bits [W-1:0].
REQ-011 SHALL have port f_i  in  1  final-block flag.
REQ-012 SHALL have port valid_o  out  1  h_o valid.
REQ-013 SHALL have port ready_i  in  1  downstream accepts h_o.
REQ-014 SHALL have port h_o  out  8*W  new chaining state, same packing as h_i.

Function
REQ-015 SHALL implement a three-state FSM IDLE -> ROUND -> DONE -> IDLE.
REQ-016 SHALL drive ready_o=1 only in IDLE; a transfer occurs on any edge where valid_i & ready_o.
REQ-017 On a transfer, SHALL register h_i and m_i, and SHALL load v[0..7]=h_i, v[8..15]=IV[0..7], with v[12]^=t_i[W-1:0], v[13]^=t_i[2W-1:W], v[14]^=all-ones when f_i=1; then SHALL enter ROUND with round counter rc=0.
REQ-018 SHALL ignore h_i, m_i, t_i and f_i whenever no transfer occurs; upstream need not hold them stable after the transfer.
REQ-019 In ROUND, each edge SHALL apply one full round to v: the column G stage on (0,4,8,12) … (3,7,11,15), then the diagonal G stage on (0,5,10,15) … (3,4,9,14).
REQ-020 Message word selection SHALL use SIGMA[rc mod 10]; pair k uses m[s[2k]] and m[s[2k+1]].
REQ-021 All additions SHALL be modulo 2^W; carries SHALL be discarded.
REQ-022 On the edge completing rc=NR-1, SHALL enter DONE; the transfer-to-valid_o latency is exactly NR+1 edges (13 for W=64, 11 for W=32).
REQ-023 In DONE, SHALL assert valid_o=1 and drive h_o[k]=h_q[k]^v[k]^v[k+8], held stable until ready_i=1.
REQ-024 On an edge in DONE with ready_i=1, SHALL return to IDLE; ready_o SHALL be 0 in that same cycle (no overlapped accept).
REQ-025 Outside DONE, SHALL hold h_o at all-zero.
REQ-026 Outside IDLE, SHALL ignore valid_i.
REQ-027 In IDLE and DONE, ready_i SHALL have no effect other than REQ-024.

Reset
REQ-028 When nreset=0 at an edge, SHALL enter IDLE with rc=0; after that edge ready_o=1, valid_o=0 and h_o=0.
REQ-029 Reset during ROUND or DONE SHALL abort the block: no valid_o for the aborted block, and the next transfer is processed normally.
REQ-030 The v, h_q and m registers SHALL NOT require reset.

Structure
REQ-031 SHALL take from shared package blake2_pkg: IV tables for both widths (IV64[8], IV32[8]), SIGMA[10][16] of 4-bit indices, and the rotation/round constants per width.
REQ-032 SHALL use sub-module blake2_g, parameterised by W, R1, R2, R3 and R4: a purely combinational G(a,b,c,d,x,y) returning the new a, b, c, d; instantiated 8 times (4 column, 4 diagonal).
REQ-033 SHALL keep the sigma row select and the 16 message muxes in blake2_compress.

Verification
REQ-034 W=64, h=IV^{0x01010040 in word 0}, m="abc" zero-padded, t=3, f=1 -> valid_o exactly 13 edges after the transfer; h_o = BA80A53F981C4D0D6A2797B69F12F6E94C212F14685AC4B74B12BB6FDBFFA2D17D87C5392AAB792DC252D5DE4533CC9518D38AA8DBF1925AB92386EDD4009923 as little-endian bytes.
REQ-035 W=32, h=IV^{0x01010020 in word 0}, m="abc", t=3, f=1 -> valid_o after 11 edges; h_o = 508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982.
REQ-036 Hold ready_i=0 for 5 cycles after valid_o -> valid_o and h_o stable throughout, ready_o=0; one ready_i pulse -> IDLE, ready_o=1 the next cycle.
REQ-037 Assert valid_i with random data during ROUND and DONE -> no effect on h_o; change h_i/m_i after the transfer -> h_o unchanged from REQ-034.
REQ-038 Pulse nreset=0 at rc=5 -> valid_o never rises for that block; a new transfer of REQ-034 data -> correct digest after 13 edges.
REQ-039 Back-to-back blocks with ready_i tied to 1 (two-block "abc"-style chain, f=0 then f=1) -> one idle cycle between blocks; second h_o matches the software model.
